// File: rtl/uart_tx_frame_serializer_pkg.sv
// uart_pkg: shared types for the UART TX frame serializer.
// Holds the FSM state enum, parity-mode codes and has_parity().
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  function automatic logic has_parity(
    input logic [1:0] ptype
  );
    return (ptype == PAR_ODD) ||
           (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_frame_serializer_if.sv
// Serializer bus: tick/request/config in, line/status out.
// master = upstream driver, slave = serializer.
interface uart_tx_frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  BaudTick;
  logic                  Send;
  logic [DATA_WIDTH-1:0] RegIn;
  logic                  ParityOut;
  logic [1:0]            ParityType;
  logic                  StopBits;
  logic                  DataTx;
  logic                  Busy;
  logic                  Done;

  modport master (
    output BaudTick,
    output Send,
    output RegIn,
    output ParityOut,
    output ParityType,
    output StopBits,
    input  DataTx,
    input  Busy,
    input  Done
  );

  modport slave (
    input  BaudTick,
    input  Send,
    input  RegIn,
    input  ParityOut,
    input  ParityType,
    input  StopBits,
    output DataTx,
    output Busy,
    output Done
  );

endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART TX frame serializer: start, data LSB first, parity, stop(s).
// Ports: Clock, ResetN (async low), bus (slave: tick/req in, line out).
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  uart_tx_frame_serializer_if.slave    bus
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Send) begin
          shreg_d   = bus.RegIn;
          par_bit_d = bus.ParityOut;
          par_en_d  = has_parity(bus.ParityType);
          stop2_d   = bus.StopBits;
          busy_d    = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Line stays idle until the next tick so
        // the start bit lands on the tick grid.
        if (bus.BaudTick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bus.BaudTick) begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // cnt_q is the index of the bit now on the line.
        if (bus.BaudTick) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP1;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.BaudTick) begin
          tx_d    = 1'b1;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bus.BaudTick) begin
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      STOP2: begin
        if (bus.BaudTick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.DataTx = tx_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule
